// File: rtl/ldpc_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_pkg
//
// Shared constants and helpers for the DVB-S2 LDPC datapath.
//
//   CIRC_WIDTH   : circulant group width in bits (360).
//   CIRC_SHIFT_W : width of a circulant shift amount (9 bits, 0..511).
//   CIRC_REG_EN  : default stage register mask for the rotators. Bits 2, 5
//                  and 8 set gives three pipeline registers spread evenly
//                  over the nine log stages.
//   mod_shift()  : folds a raw shift amount into 0..width-1. A single
//                  subtraction is enough because the largest 9-bit shift
//                  (511) is below 2*360.
//
// No ports (package).
// ---------------------------------------------------------------------------
package ldpc_pkg;

    localparam int unsigned CIRC_WIDTH   = 360;
    localparam int unsigned CIRC_SHIFT_W = 9;
    localparam logic [31:0] CIRC_REG_EN  = 32'h124;

    function automatic int unsigned mod_shift(input int unsigned shift,
                                              input int unsigned width);
        return (shift >= width) ? (shift - width) : shift;
    endfunction

endpackage

// File: rtl/barrel_unshift_stage.sv
// ---------------------------------------------------------------------------
// barrel_unshift_stage
//
// One log stage of the inverse circulant rotator. When the shift bit that
// belongs to this stage (bit log2(SHIFT_VAL)) is set, the group is rotated
// toward lower indices by SHIFT_VAL:
//     out_data[j] = in_data[(j + SHIFT_VAL) mod WIDTH]
// otherwise it passes through unchanged. The whole shift word travels with
// the data so later stages can pick their own bit.
//
// REG = 1 : the stage result is registered with a valid bit and a
//           skid-free ready: the register loads when it is empty or when
//           the downstream side takes the current beat this cycle.
// REG = 0 : purely combinational; valid and ready pass straight through.
//
// Optional feature (macro BARREL_UNSHIFT_RANGE_CHK_EN): adds in_err/out_err,
// a one-bit sideband that travels with the beat. Without the macro the
// ports and the register do not exist.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   in_data    group from the previous stage
//   in_shift   reduced shift word from the previous stage
//   in_err     (macro only) out-of-range flag from the previous stage
//   in_valid   beat valid from the previous stage
//   in_ready   this stage accepts the beat this cycle
//   out_data   group toward the next stage
//   out_shift  shift word toward the next stage
//   out_err    (macro only) out-of-range flag toward the next stage
//   out_valid  beat valid toward the next stage
//   out_ready  next stage accepts the beat this cycle
// ---------------------------------------------------------------------------
module barrel_unshift_stage
    import ldpc_pkg::*;
#(
    parameter int unsigned WIDTH     = CIRC_WIDTH,
    parameter int unsigned SHIFT_W   = CIRC_SHIFT_W,
    parameter int unsigned SHIFT_VAL = 1,
    parameter bit          REG       = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHIFT_W-1:0] in_shift,
`ifdef BARREL_UNSHIFT_RANGE_CHK_EN
    input  logic               in_err,
    output logic               out_err,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SHIFT_W-1:0] out_shift,
    output logic               out_valid,
    input  logic               out_ready
);

    // SHIFT_VAL is a power of two; its log picks the controlling shift bit.
    localparam int unsigned SEL_BIT = $clog2(SHIFT_VAL);

    logic [WIDTH-1:0] rot_data;
    logic [WIDTH-1:0] next_data;

    // Downward rotation: the low SHIFT_VAL bits wrap around to the top.
    assign rot_data  = {in_data[SHIFT_VAL-1:0], in_data[WIDTH-1:SHIFT_VAL]};
    assign next_data = in_shift[SEL_BIT] ? rot_data : in_data;

    if (REG) begin : g_reg
        logic               vld_q;
        logic [WIDTH-1:0]   data_q;
        logic [SHIFT_W-1:0] shift_q;
        logic               load;

        // Loading whenever the register is empty lets bubbles collapse.
        assign load = !vld_q || out_ready;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q   <= 1'b0;
                data_q  <= '0;
                shift_q <= '0;
            end else if (load) begin
                vld_q <= in_valid;
                // Only capture real beats so idle inputs never disturb
                // the held payload.
                if (in_valid) begin
                    data_q  <= next_data;
                    shift_q <= in_shift;
                end
            end
        end

`ifdef BARREL_UNSHIFT_RANGE_CHK_EN
        logic err_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                err_q <= 1'b0;
            end else if (load && in_valid) begin
                err_q <= in_err;
            end
        end

        assign out_err = err_q;
`endif

        assign in_ready  = load;
        assign out_valid = vld_q;
        assign out_data  = data_q;
        assign out_shift = shift_q;
    end else begin : g_comb
        // The clock and reset are not needed in a combinational stage.
        logic unused_clk;
        assign unused_clk = clk ^ rst_n;

`ifdef BARREL_UNSHIFT_RANGE_CHK_EN
        assign out_err   = in_err;
`endif
        assign in_ready  = out_ready;
        assign out_valid = in_valid;
        assign out_data  = next_data;
        assign out_shift = in_shift;
    end

endmodule

// File: rtl/barrel_unshift.sv
// ---------------------------------------------------------------------------
// barrel_unshift
//
// Receiver-side inverse circulant rotator for the DVB-S2 LDPC datapath.
// Undoes the encoder rotation of one circulant group:
//     out_data[j] = in_data[(j + s) mod WIDTH]
// where s is in_shift folded into 0..WIDTH-1. A forward (upward) rotation by
// the same amount followed by this block is the identity.
//
// The rotation is a chain of SHIFT_VAL_WIDTH log stages; stage k rotates
// down by 2^k when shift bit k is set. REG_EN bit k places a register after
// stage k, so the latency is popcount(REG_EN) cycles (3 by default). With
// REG_EN = 0 the block is combinational and valid/ready pass straight
// through. Each registered stage carries its own valid bit and loads when
// empty or when its downstream advances, so the pipeline holds one beat per
// register and sustains one beat per cycle when out_ready stays high.
//
// When the last stage is not registered, out_data follows the input path
// rather than clearing on reset.
//
// Optional feature: define BARREL_UNSHIFT_RANGE_CHK_EN to add out_err,
// which flags a beat whose in_shift was >= WIDTH. The data is folded either
// way; without the macro there is no out_err port and no extra register.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   in_data    group to un-rotate
//   in_shift   rotation amount applied by the encoder (0..2^W-1)
//   in_valid   in_data/in_shift valid
//   in_ready   block accepts the beat this cycle
//   out_data   un-rotated group
//   out_valid  out_data valid
//   out_err    (macro only) beat had an out-of-range shift
//   out_ready  downstream accepts the beat
// ---------------------------------------------------------------------------
module barrel_unshift
    import ldpc_pkg::*;
#(
    parameter int unsigned WIDTH           = CIRC_WIDTH,
    parameter int unsigned SHIFT_VAL_WIDTH = CIRC_SHIFT_W,
    parameter logic [31:0] REG_EN          = CIRC_REG_EN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [SHIFT_VAL_WIDTH-1:0] in_shift,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
`ifdef BARREL_UNSHIFT_RANGE_CHK_EN
    output logic                       out_err,
`endif
    input  logic                       out_ready
);

    localparam int unsigned NSTG = SHIFT_VAL_WIDTH;

    // Index k is the input of stage k; index NSTG is the block output.
    logic [WIDTH-1:0]           stg_data  [0:NSTG];
    logic [SHIFT_VAL_WIDTH-1:0] stg_shift [0:NSTG];
    logic                       stg_valid [0:NSTG];
    logic                       stg_ready [0:NSTG];

    logic [SHIFT_VAL_WIDTH-1:0] red_shift;

    // Fold the shift ahead of stage 0 so every stage sees 0..WIDTH-1.
    assign red_shift = SHIFT_VAL_WIDTH'(mod_shift(32'(in_shift), WIDTH));

    assign stg_data[0]  = in_data;
    assign stg_shift[0] = red_shift;
    assign stg_valid[0] = in_valid;

    // Gated with rst_n so upstream never sees a transfer during reset.
    assign in_ready = rst_n & stg_ready[0];

    assign stg_ready[NSTG] = out_ready;
    assign out_data        = stg_data[NSTG];
    assign out_valid       = stg_valid[NSTG];

    // Every shift bit has been consumed once the last stage is passed.
    logic unused_shift;
    assign unused_shift = ^stg_shift[NSTG];

`ifdef BARREL_UNSHIFT_RANGE_CHK_EN
    logic stg_err [0:NSTG];

    assign stg_err[0] = (32'(in_shift) >= WIDTH);
    assign out_err    = stg_err[NSTG];
`endif

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        barrel_unshift_stage #(
            .WIDTH     (WIDTH),
            .SHIFT_W   (SHIFT_VAL_WIDTH),
            .SHIFT_VAL (1 << k),
            .REG       (REG_EN[k])
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_data   (stg_data[k]),
            .in_shift  (stg_shift[k]),
`ifdef BARREL_UNSHIFT_RANGE_CHK_EN
            .in_err    (stg_err[k]),
            .out_err   (stg_err[k+1]),
`endif
            .in_valid  (stg_valid[k]),
            .in_ready  (stg_ready[k]),
            .out_data  (stg_data[k+1]),
            .out_shift (stg_shift[k+1]),
            .out_valid (stg_valid[k+1]),
            .out_ready (stg_ready[k+1])
        );
    end

endmodule

// File: tb/tb_barrel_unshift.sv
// ---------------------------------------------------------------------------
// tb_barrel_unshift
//
// Bench for barrel_unshift with default parameters (WIDTH=360, 9 stages,
// REG_EN='h124, latency 3). Accepted beats push their expected group onto a
// queue; delivered beats pop and compare. Works with and without
// BARREL_UNSHIFT_RANGE_CHK_EN.
// ---------------------------------------------------------------------------
module tb_barrel_unshift;

    localparam int W = 360;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic [8:0]   in_shift;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
`ifdef BARREL_UNSHIFT_RANGE_CHK_EN
    logic         out_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    beat_t        exp_q[$];
    beat_t        e;
    logic [W-1:0] cur_exp;
    logic         cur_err;

    always #5 clk = ~clk;

    barrel_unshift dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
`ifdef BARREL_UNSHIFT_RANGE_CHK_EN
        .out_err   (out_err),
`endif
        .out_ready (out_ready)
    );

    // Encoder-side reference: bit i moves up to (i + r) mod W.
    function automatic logic [W-1:0] fwd_rot(input logic [W-1:0] x, input int r);
        logic [W-1:0] y;
        for (int i = 0; i < W; i++) y[(i + r) % W] = x[i];
        return y;
    endfunction

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] y;
        for (int i = 0; i < W; i++) y[i] = 1'($urandom);
        return y;
    endfunction

    function automatic logic [W-1:0] one_hot(input int b);
        logic [W-1:0] y;
        y    = '0;
        y[b] = 1'b1;
        return y;
    endfunction

    // Scoreboard: pop/compare delivered beats, push accepted ones.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra_beat: got beat %h, none expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data) begin
                        n_fail++;
                        $display("FAIL sb_data: got %h expected %h", out_data, e.data);
                    end
`ifdef BARREL_UNSHIFT_RANGE_CHK_EN
                    n_checks++;
                    if (out_err !== e.err) begin
                        n_fail++;
                        $display("FAIL sb_err: got %b expected %b", out_err, e.err);
                    end
`endif
                    n_out++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back('{cur_exp, cur_err});
        end
    end

    task automatic drive_raw(input logic [W-1:0] d, input int s,
                             input logic [W-1:0] exp, input logic err);
        in_valid = 1'b1;
        in_data  = d;
        in_shift = 9'(s);
        cur_exp  = exp;
        cur_err  = err;
    endtask

    task automatic drive(input logic [W-1:0] orig, input int s);
        int r;
        r = (s >= W) ? s - W : s;
        drive_raw(fwd_rot(orig, r), s, orig, s >= W);
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] orig, input int s);
        drive(orig, s);
        wait_accept();
    endtask

    task automatic send_raw(input logic [W-1:0] d, input int s,
                            input logic [W-1:0] exp, input logic err);
        drive_raw(d, s, exp, err);
        wait_accept();
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        in_data   = 'x;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 'x;
        in_shift  = '0;
        out_ready = 1'b1;
        cur_exp   = '0;
        cur_err   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h required 0", out_data); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b required 0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        logic exp_v;
        out_ready = 1'b1;
        send_raw(one_hot(5), 3, one_hot(2), 1'b0);
        in_valid = 1'b0;
        in_data  = 'x;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            exp_v = (c == 3);
            n_checks++;
            if (out_valid !== exp_v) begin
                n_fail++;
                $display("FAIL latency_valid: cycle %0d out_valid=%b required %b", c, out_valid, exp_v);
            end
            if (c == 3) begin
                n_checks++;
                if (out_data !== one_hot(2)) begin
                    n_fail++;
                    $display("FAIL latency_data: got %h required one-hot bit 2", out_data);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_identity();
        logic [W-1:0] d;
        int           base;
        base = n_out;
        out_ready = 1'b1;
        send_raw(one_hot(0), 359, one_hot(1), 1'b0);
        d = rand_data();
        send_raw(d, 0, d, 1'b0);
        d = rand_data();
        send_raw(d, 360, d, 1'b1);
        drain();
        n_checks++;
        if (n_out - base !== 3) begin
            n_fail++;
            $display("FAIL identity_count: got %0d beats required 3", n_out - base);
        end
    endtask

    task automatic test_range();
        int base;
        base = n_out;
        out_ready = 1'b1;
        send(rand_data(), 17);
        send_raw(one_hot(40), 400, one_hot(0), 1'b1);
        send(rand_data(), 359);
        send(rand_data(), 511);
        drain();
        n_checks++;
        if (n_out - base !== 4) begin
            n_fail++;
            $display("FAIL range_count: got %0d beats required 4", n_out - base);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] b [4];
        int           cnt;
        int           last;
        for (int i = 0; i < 4; i++) b[i] = rand_data();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(b[i], 50 * i + 7);
            @(negedge clk);
            n_checks++;
            if (in_ready !== (i < 3)) begin
                n_fail++;
                $display("FAIL stall_in_ready: beat %0d in_ready=%b required %b", i, in_ready, i < 3);
            end
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks += 3;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_hold_ready: got %b required 0", in_ready); end
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_valid: got %b required 1", out_valid); end
            if (out_data !== b[0]) begin n_fail++; $display("FAIL stall_hold_data: got %h required %h", out_data, b[0]); end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        cnt  = 0;
        last = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_checks++;
                if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b required 1", in_ready); end
            end
            if (out_valid) begin
                cnt++;
                last = c;
            end
            @(posedge clk);
            #1;
            if (c == 0) begin
                in_valid = 1'b0;
                in_data  = 'x;
            end
        end
        n_checks += 2;
        if (cnt !== 4) begin n_fail++; $display("FAIL release_count: got %0d beats required 4", cnt); end
        if (last !== 3) begin n_fail++; $display("FAIL release_back_to_back: last beat cycle %0d required 3", last); end
    endtask

    task automatic test_back_to_back();
        int cnt;
        int first;
        int last;
        cnt   = 0;
        first = -1;
        last  = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (c < 16) drive(rand_data(), $urandom_range(0, 511));
            else begin
                in_valid = 1'b0;
                in_data  = 'x;
            end
            @(negedge clk);
            if (c < 16) begin
                n_checks++;
                if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: cycle %0d got %b required 1", c, in_ready); end
            end
            if (out_valid) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
            @(posedge clk);
            #1;
        end
        n_checks += 3;
        if (cnt !== 16) begin n_fail++; $display("FAIL b2b_count: got %0d required 16", cnt); end
        if (first !== 3) begin n_fail++; $display("FAIL b2b_latency: first output cycle %0d required 3", first); end
        if (last - first !== 15) begin n_fail++; $display("FAIL b2b_throughput: span %0d required 15", last - first); end
    endtask

    task automatic test_random();
        int  sent;
        int  cyc;
        int  base;
        logic acc;
        sent = 0;
        cyc  = 0;
        acc  = 1'b0;
        base = n_out;
        in_valid = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            if (acc) begin
                in_valid = 1'b0;
                in_data  = 'x;
            end
            if (!in_valid && $urandom_range(0, 3) != 0) drive(rand_data(), $urandom_range(0, 511));
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        drain();
        n_checks += 2;
        if (sent !== 1000) begin n_fail++; $display("FAIL random_sent: got %0d required 1000", sent); end
        if (n_out - base !== 1000) begin n_fail++; $display("FAIL random_delivered: got %0d required 1000", n_out - base); end
    endtask

    task automatic test_midreset();
        int cnt;
        out_ready = 1'b1;
        send(rand_data(), 123);
        send(rand_data(), 456);
        in_valid = 1'b0;
        in_data  = 'x;
        rst_n    = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_in_ready_low: got %b required 0", in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b required 0", out_valid); end
        if (out_data !== '0) begin n_fail++; $display("FAIL midreset_out_data: got %h required 0", out_data); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b required 1", in_ready); end
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        n_checks++;
        if (cnt !== 0) begin n_fail++; $display("FAIL midreset_stale: %0d stale beats, required 0", cnt); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_identity();
        test_range();
        test_stall();
        test_back_to_back();
        test_random();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
